// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 results and drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | accepting results from MEM; non-loads retire with latency 1
// LOAD_WAIT  | load accepted, waiting for data-memory response or timeout
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_wb_sel,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_pc_plus4,
    input  logic [2:0]  i_load_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wr,
    output logic [4:0]  o_rd,
    output logic [31:0] o_write_data,
    output logic        o_pending,
    output logic [4:0]  o_pending_rd,
    output logic        o_load_err,
    output logic [63:0] o_instret
);

    localparam logic S_IDLE      = 1'b0;
    localparam logic S_LOAD_WAIT = 1'b1;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int TW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam bit TMO_EN = (LOAD_TIMEOUT != 0);
    // Down-counter loaded so that it reaches zero on the LOAD_TIMEOUT-th waiting cycle.
    localparam logic [TW-1:0] TMR_INIT = TW'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

    logic          state;
    logic [TW-1:0] tmr;
    logic [4:0]    ld_rd;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_lsb;

    logic          xfer;
    logic          is_load;
    logic          ld_legal;
    logic          tmo_hit;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    assign o_ready = (state == S_IDLE) & ~rst;
    assign xfer    = i_valid & o_ready;
    assign is_load = (i_wb_sel == SEL_LOAD);
    assign tmo_hit = TMO_EN && (tmr == '0);

    always_comb begin
        ld_legal = 1'b0;
        case (i_load_funct3)
            3'b000, 3'b100: ld_legal = 1'b1;
            3'b001, 3'b101: ld_legal = ~i_addr_lsb[0];
            3'b010:         ld_legal = (i_addr_lsb == 2'b00);
            default:        ld_legal = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (ld_lsb)
            2'd0: ld_byte = i_dmem_rdata[7:0];
            2'd1: ld_byte = i_dmem_rdata[15:8];
            2'd2: ld_byte = i_dmem_rdata[23:16];
            2'd3: ld_byte = i_dmem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = ld_lsb[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ld_data = i_dmem_rdata;
        case (ld_f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            tmr          <= '0;
            ld_rd        <= '0;
            ld_f3        <= '0;
            ld_lsb       <= '0;
            o_wr         <= 1'b0;
            o_rd         <= '0;
            o_write_data <= '0;
            o_pending    <= 1'b0;
            o_pending_rd <= '0;
            o_load_err   <= 1'b0;
        end else begin
            o_wr       <= 1'b0;
            o_load_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (is_load) begin
                            if (ld_legal) begin
                                state        <= S_LOAD_WAIT;
                                tmr          <= TMR_INIT;
                                ld_rd        <= i_rd;
                                ld_f3        <= i_load_funct3;
                                ld_lsb       <= i_addr_lsb;
                                o_pending    <= 1'b1;
                                o_pending_rd <= i_rd;
                            end else begin
                                o_load_err <= 1'b1;
                            end
                        end else begin
                            o_wr         <= (i_wb_sel != SEL_NONE) && (i_rd != 5'd0);
                            o_rd         <= i_rd;
                            o_write_data <= (i_wb_sel == SEL_PC4) ? i_pc_plus4 : i_alu_result;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    // A response in the timeout cycle still completes the load.
                    if (i_dmem_rvalid) begin
                        state        <= S_IDLE;
                        o_wr         <= (ld_rd != 5'd0);
                        o_rd         <= ld_rd;
                        o_write_data <= ld_data;
                        o_pending    <= 1'b0;
                        o_pending_rd <= '0;
                    end else if (tmo_hit) begin
                        state        <= S_IDLE;
                        o_load_err   <= 1'b1;
                        o_pending    <= 1'b0;
                        o_pending_rd <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    logic retire;
    assign retire = (xfer & ~is_load) | ((state == S_LOAD_WAIT) & i_dmem_rvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_instret <= '0;
        end else if (retire) begin
            o_instret <= o_instret + 64'd1;
        end
    end
`else
    assign o_instret = '0;
`endif

endmodule
